mem_io_responder: RTL and testbench



---
 rtl/io_map_pkg.sv | 37 +++
 rtl/uart_buf.sv | 46 ++++
 rtl/mem_io_responder.sv | 132 +++++++++++++
 tb/tb_mem_io_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// Shared address map for the core's data-memory responder: region codes,
// I/O register offsets and status bit positions.
package io_map_pkg;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_DMEM = 2'd1,
        REGION_IMEM = 2'd2,
        REGION_IO   = 2'd3
    } region_e;

    localparam logic [7:0] IO_STATUS  = 8'h00;
    localparam logic [7:0] IO_RX      = 8'h04;
    localparam logic [7:0] IO_TX      = 8'h08;
    localparam logic [7:0] IO_CYC     = 8'h10;
    localparam logic [7:0] IO_INST    = 8'h14;
    localparam logic [7:0] IO_CNT_RST = 8'h18;

    localparam int STAT_TX_FREE = 0;
    localparam int STAT_RX_FULL = 1;

    // 0011 matches both the DMEM and IMEM patterns; DMEM takes priority.
    function automatic region_e decode_region(input logic [3:0] top);
        region_e r;
        if ((top[3:2] == 2'b00) && top[0]) begin
            r = REGION_DMEM;
        end else if (top[3:1] == 3'b001) begin
            r = REGION_IMEM;
        end else if (top == 4'b1000) begin
            r = REGION_IO;
        end else begin
            r = REGION_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_buf.sv
// One-entry UART transmit and receive buffers with valid/ready handshakes.
module uart_buf (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_load,
    input  logic [7:0] tx_byte,
    input  logic       rx_clear,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] rx_buf,
    output logic       rx_full
);

    // TX entry: a load while a byte is still pending is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end else if (tx_load && !tx_valid) begin
            tx_data  <= tx_byte;
            tx_valid <= 1'b1;
        end
    end

    // RX entry: ready is low while full, so capture and clear are exclusive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_full <= 1'b0;
            rx_buf  <= 8'h00;
        end else if (rx_valid && !rx_full) begin
            rx_buf  <= rx_data;
            rx_full <= 1'b1;
        end else if (rx_clear) begin
            rx_full <= 1'b0;
        end
    end

    assign rx_ready = ~rx_full;

endmodule

// File: rtl/mem_io_responder.sv
// Responder for the core's data-memory port: decodes M-stage accesses to
// DMEM, IMEM or memory-mapped I/O and returns read data aligned with W.
module mem_io_responder
    import io_map_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DMEM_AW = 14,
    parameter int IMEM_AW = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    mem_adrM,
    input  logic [XLEN-1:0]    mem_wdataM,
    input  logic [3:0]         wea,
    input  logic               mem_re,
    input  logic               instr_stop,
    input  logic               imem_wr_en,
    output logic [XLEN-1:0]    din,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_din,
    output logic [3:0]         dmem_we,
    input  logic [XLEN-1:0]    dmem_dout,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [XLEN-1:0]    imem_din,
    output logic [3:0]         imem_we,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready
);

    region_e          region_s;
    region_e          sel_q;
    logic [7:0]       io_off_s;
    logic             io_wr_s;
    logic             tx_load_s;
    logic             rx_clear_s;
    logic             cnt_rst_s;
    logic [31:0]      cyc_r;
    logic [31:0]      inst_r;
    logic [XLEN-1:0]  io_rd_s;
    logic [XLEN-1:0]  io_q;
    logic [7:0]       rx_buf_s;
    logic             rx_full_s;
    logic             unused_s;

    assign region_s   = decode_region(mem_adrM[31:28]);
    assign io_off_s   = mem_adrM[7:0];
    assign io_wr_s    = (region_s == REGION_IO) && (wea != 4'h0);
    assign tx_load_s  = io_wr_s && (io_off_s == IO_TX);
    assign cnt_rst_s  = io_wr_s && (io_off_s == IO_CNT_RST);
    assign rx_clear_s = (region_s == REGION_IO) && mem_re && (io_off_s == IO_RX);
    assign unused_s   = ^{mem_adrM, mem_wdataM};

    assign dmem_addr = mem_adrM[DMEM_AW+1:2];
    assign dmem_din  = mem_wdataM;
    assign dmem_we   = (region_s == REGION_DMEM) ? wea : 4'h0;
    assign imem_addr = mem_adrM[IMEM_AW+1:2];
    assign imem_din  = mem_wdataM;
    assign imem_we   = ((region_s == REGION_IMEM) && imem_wr_en) ? wea : 4'h0;

    uart_buf u_uart_buf (
        .clk      (clk),
        .rst      (rst),
        .tx_load  (tx_load_s),
        .tx_byte  (mem_wdataM[7:0]),
        .rx_clear (rx_clear_s),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_buf   (rx_buf_s),
        .rx_full  (rx_full_s)
    );

    // Cycle and retired-instruction counters; a reset write beats the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_r  <= 32'd0;
            inst_r <= 32'd0;
        end else if (cnt_rst_s) begin
            cyc_r  <= 32'd0;
            inst_r <= 32'd0;
        end else begin
            cyc_r <= cyc_r + 32'd1;
            if (!instr_stop) begin
                inst_r <= inst_r + 32'd1;
            end
        end
    end

    // I/O read value for the current offset, sampled before any same-cycle write.
    always_comb begin
        io_rd_s = {XLEN{1'b0}};
        case (io_off_s)
            IO_STATUS: begin
                io_rd_s[STAT_TX_FREE] = ~tx_valid;
                io_rd_s[STAT_RX_FULL] = rx_full_s;
            end
            IO_RX:   io_rd_s[7:0] = rx_buf_s;
            IO_CYC:  io_rd_s = XLEN'(cyc_r);
            IO_INST: io_rd_s = XLEN'(inst_r);
            default: io_rd_s = {XLEN{1'b0}};
        endcase
    end

    // Read-return registers, captured every cycle to line up with W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= REGION_NONE;
            io_q  <= {XLEN{1'b0}};
        end else begin
            sel_q <= region_s;
            io_q  <= io_rd_s;
        end
    end

    // DMEM data arrives a cycle after its address, so din is muxed after the flop.
    always_comb begin
        din = {XLEN{1'b0}};
        case (sel_q)
            REGION_DMEM: din = dmem_dout;
            REGION_IO:   din = io_q;
            default:     din = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: sync-RAM model behind the DMEM
// port and a queue of expected read data checked one cycle after each load.
module tb_mem_io_responder;

    localparam logic [31:0] IDLE_ADR = 32'h5000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_adrM = 32'h0;
    logic [31:0] mem_wdataM = 32'h0;
    logic [3:0]  wea = 4'h0;
    logic        mem_re = 1'b0;
    logic        instr_stop = 1'b0;
    logic        imem_wr_en = 1'b0;
    logic [31:0] din;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_din;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_dout;
    logic [13:0] imem_addr;
    logic [31:0] imem_din;
    logic [3:0]  imem_we;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;
    logic        rd_pend = 1'b0;
    logic [31:0] ram [0:15];

    mem_io_responder #(.XLEN(32), .DMEM_AW(14), .IMEM_AW(14)) dut (
        .clk(clk), .rst(rst), .mem_adrM(mem_adrM), .mem_wdataM(mem_wdataM),
        .wea(wea), .mem_re(mem_re), .instr_stop(instr_stop), .imem_wr_en(imem_wr_en),
        .din(din), .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_we(dmem_we),
        .dmem_dout(dmem_dout), .imem_addr(imem_addr), .imem_din(imem_din),
        .imem_we(imem_we), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    // Synchronous-read data memory sitting behind the DMEM port
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (dmem_we[b]) ram[dmem_addr[3:0]][8*b +: 8] <= dmem_din[8*b +: 8];
        end
        dmem_dout <= ram[dmem_addr[3:0]];
    end

    // Scoreboard: a load issued in cycle N is checked against the queue in cycle N+1
    always @(posedge clk) rd_pend <= mem_re && !rst;
    always @(negedge clk) begin
        if (rd_pend) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL din_sb underflow: got %h, nothing expected", din);
            end else begin
                sb_exp = exp_q.pop_front();
                if (din !== sb_exp) begin
                    failures++;
                    $display("FAIL din_sb: got %h expected %h", din, sb_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        mem_adrM = a; mem_re = 1'b1; wea = 4'h0;
        exp_q.push_back(e);
        step();
        mem_re = 1'b0; mem_adrM = IDLE_ADR;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        mem_adrM = a; mem_wdataM = d; wea = w; mem_re = 1'b0;
        step();
        wea = 4'h0; mem_adrM = IDLE_ADR;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (din !== 32'h0) begin failures++; $display("FAIL rst_din: got %h expected 0", din); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h0) begin failures++; $display("FAIL rst_tx_data: got %h expected 0", tx_data); end
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL rst_rx_ready: got %b expected 1", rx_ready); end
        checks++; if ({dmem_we, imem_we} !== 8'h0) begin failures++; $display("FAIL rst_we: got %h expected 0", {dmem_we, imem_we}); end
        @(negedge clk); rst = 1'b0;
        step();
        rd(32'h8000_0000, 32'h1);
        rd(32'h8000_0004, 32'h0);
    endtask

    task automatic test_dmem();
        mem_adrM = 32'h1000_0004; mem_wdataM = 32'hDEAD_BEEF; wea = 4'hF; #1;
        checks++; if (dmem_we !== 4'hF) begin failures++; $display("FAIL dmem_we: got %h expected f", dmem_we); end
        checks++; if (dmem_addr !== 14'd1) begin failures++; $display("FAIL dmem_addr: got %0d expected 1", dmem_addr); end
        checks++; if (dmem_din !== 32'hDEAD_BEEF) begin failures++; $display("FAIL dmem_din: got %h expected deadbeef", dmem_din); end
        checks++; if (imem_we !== 4'h0) begin failures++; $display("FAIL dmem_imem_we: got %h expected 0", imem_we); end
        step(); wea = 4'h0;
        rd(32'h1000_0004, 32'hDEAD_BEEF);
        mem_adrM = 32'h3000_0008; mem_wdataM = 32'h0000_1234; wea = 4'h3; #1;
        checks++; if (dmem_we !== 4'h3 || dmem_addr !== 14'd2) begin failures++; $display("FAIL dmem_0011: got we %h addr %0d expected 3/2", dmem_we, dmem_addr); end
        step(); wea = 4'h0;
        rd(32'h3000_0008, 32'h0000_1234);
    endtask

    task automatic test_back_to_back();
        wr(32'h1000_000C, 32'h1111_1111, 4'hF);
        wr(32'h1000_0010, 32'h2222_2222, 4'hF);
        wr(32'h1000_0010, 32'hAB00_0000, 4'h8);
        rd(32'h1000_000C, 32'h1111_1111);
        rd(32'h1000_0010, 32'hAB22_2222);
        rd(32'h8000_0000, 32'h1);
        rd(IDLE_ADR,      32'h0);
        rd(32'h1000_000C, 32'h1111_1111);
    endtask

    task automatic test_imem_unmapped();
        mem_adrM = 32'h2000_0010; mem_wdataM = 32'h1234_5678; wea = 4'hF; imem_wr_en = 1'b0; #1;
        checks++; if (imem_we !== 4'h0 || dmem_we !== 4'h0) begin failures++; $display("FAIL imem_locked: got %h/%h expected 0/0", imem_we, dmem_we); end
        imem_wr_en = 1'b1; #1;
        checks++; if (imem_we !== 4'hF || imem_addr !== 14'd4) begin failures++; $display("FAIL imem_we: got %h addr %0d expected f/4", imem_we, imem_addr); end
        mem_adrM = IDLE_ADR; #1;
        checks++; if (imem_we !== 4'h0 || dmem_we !== 4'h0) begin failures++; $display("FAIL unmapped_we: got %h/%h expected 0/0", imem_we, dmem_we); end
        wea = 4'h0; imem_wr_en = 1'b0;
        step();
        rd(32'h2000_0010, 32'h0);
        rd(32'h5000_0000, 32'h0);
    endtask

    task automatic test_tx();
        tx_ready = 1'b0;
        wr(32'h8000_0008, 32'h0000_0041, 4'h1);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin failures++; $display("FAIL tx_load: got %b/%h expected 1/41", tx_valid, tx_data); end
        repeat (3) step();
        wr(32'h8000_0008, 32'h0000_0042, 4'h1);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin failures++; $display("FAIL tx_hold: got %b/%h expected 1/41", tx_valid, tx_data); end
        rd(32'h8000_0000, 32'h0);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL tx_done: got %b expected 0", tx_valid); end
        rd(32'h8000_0000, 32'h1);
    endtask

    task automatic test_rx();
        wr(32'h8000_0008, 32'h0000_0077, 4'h1);
        rx_data = 8'h5A; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        checks++; if (rx_ready !== 1'b0) begin failures++; $display("FAIL rx_full: got ready %b expected 0", rx_ready); end
        rx_data = 8'h11; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        rd(32'h8000_0000, 32'h2);
        rd(32'h8000_0004, 32'h5A);
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL rx_clear: got ready %b expected 1", rx_ready); end
        rd(32'h8000_0004, 32'h5A);
    endtask

    task automatic test_counters();
        instr_stop = 1'b0;
        wr(32'h8000_0018, 32'h0, 4'hF);
        for (int i = 0; i < 10; i++) begin
            instr_stop = (i % 3 == 0);
            step();
        end
        instr_stop = 1'b1;
        rd(32'h8000_0010, 32'd10);
        rd(32'h8000_0014, 32'd6);
        wr(32'h8000_0018, 32'hFFFF_FFFF, 4'h1);
        rd(32'h8000_0010, 32'd0);
        rd(32'h8000_0014, 32'd0);
        instr_stop = 1'b0;
        repeat (2) step();
        instr_stop = 1'b1;
        rd(32'h8000_0010, 32'd4);
        rd(32'h8000_0014, 32'd2);
    endtask

    task automatic test_async_reset();
        rx_data = 8'h33; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        checks++; if (rx_ready !== 1'b0 || tx_valid !== 1'b1) begin failures++; $display("FAIL ar_pre: got rx_ready %b tx_valid %b expected 0/1", rx_ready, tx_valid); end
        mem_adrM = 32'h1000_0004;
        step();
        checks++; if (din !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ar_din_pre: got %h expected deadbeef", din); end
        #1 rst = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h0) begin failures++; $display("FAIL ar_tx: got %b/%h expected 0/00", tx_valid, tx_data); end
        checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL ar_rx_ready: got %b expected 1", rx_ready); end
        checks++; if (din !== 32'h0) begin failures++; $display("FAIL ar_din: got %h expected 0", din); end
        mem_adrM = IDLE_ADR;
        @(negedge clk); rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_dmem();
        test_back_to_back();
        test_imem_unmapped();
        test_tx();
        test_rx();
        test_counters();
        test_async_reset();
        repeat (2) step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
